// File: rtl/scr1_memif.sv
// Memory interface enums shared by the core-side ports of the TCM and other memory agents.
package scr1_memif;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage

// File: rtl/scr1_tcm_pkg.sv
// TCM arbiter shared types: response owner, arbitration pointer and byte-lane mask helper.
package scr1_tcm_pkg;
  import scr1_memif::*;

  localparam int unsigned TCM_LANE_MAX = 8;

  typedef enum logic [1:0] {
    TCM_OWNER_NONE = 2'b00,
    TCM_OWNER_IMEM = 2'b01,
    TCM_OWNER_DMEM = 2'b10
  } tcm_owner_e;

  typedef enum logic {
    TCM_PTR_IMEM = 1'b0,
    TCM_PTR_DMEM = 1'b1
  } tcm_ptr_e;

  // Width mask moved to the byte lane selected by the address offset
  function automatic logic [TCM_LANE_MAX-1:0] tcm_lane_mask(input type_scr1_mem_width_e width,
                                                            input logic [2:0] offset);
    logic [TCM_LANE_MAX-1:0] base;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  base = 8'h01;
      SCR1_MEM_WIDTH_HWORD: base = 8'h03;
      default:              base = 8'h0F;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/scr1_tcm_arb_sel.sv
// Grant selection between imem and dmem: round-robin pointer or dmem priority with starvation guard.
module scr1_tcm_arb_sel
  import scr1_tcm_pkg::*;
#(
  parameter int unsigned ARB_MODE   = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic imem_req,
  input  logic dmem_req,
  output logic imem_gnt_c,
  output logic dmem_gnt_c
);

  localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  tcm_ptr_e        ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= TCM_PTR_IMEM;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // No grant while in reset so nothing issued then can produce a response
  always_comb begin
    imem_gnt_c = 1'b0;
    dmem_gnt_c = 1'b0;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    if (!rst) begin
      if (imem_req && dmem_req) begin
        if (ARB_MODE == 0) begin
          if (cnt_q >= CW'(STARVE_MAX)) imem_gnt_c = 1'b1;
          else                          dmem_gnt_c = 1'b1;
        end else if (ptr_q == TCM_PTR_IMEM) begin
          dmem_gnt_c = 1'b1;
        end else begin
          imem_gnt_c = 1'b1;
        end
      end else begin
        imem_gnt_c = imem_req;
        dmem_gnt_c = dmem_req;
      end

      if (imem_gnt_c)      ptr_d = TCM_PTR_IMEM;
      else if (dmem_gnt_c) ptr_d = TCM_PTR_DMEM;

      if (!imem_req || imem_gnt_c)      cnt_d = '0;
      else if (cnt_q < CW'(STARVE_MAX)) cnt_d = cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/scr1_tcm_arb.sv
// Two-port (imem/dmem) arbiter in front of a single-port TCM with 1-cycle read latency.
module scr1_tcm_arb
  import scr1_memif::*;
  import scr1_tcm_pkg::*;
#(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned TCM_SIZE   = 65536,
  parameter int unsigned ARB_MODE   = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        imem_req,
  input  logic [31:0]                                 imem_addr,
  output logic                                        imem_req_ack,
  output logic [DWIDTH-1:0]                           imem_rdata,
  output type_scr1_mem_resp_e                         imem_resp,
  input  logic                                        dmem_req,
  input  type_scr1_mem_cmd_e                          dmem_cmd,
  input  type_scr1_mem_width_e                        dmem_width,
  input  logic [31:0]                                 dmem_addr,
  input  logic [DWIDTH-1:0]                           dmem_wdata,
  output logic                                        dmem_req_ack,
  output logic [DWIDTH-1:0]                           dmem_rdata,
  output type_scr1_mem_resp_e                         dmem_resp,
  output logic                                        mem_en,
  output logic                                        mem_we,
  output logic [DWIDTH/8-1:0]                         mem_be,
  output logic [$clog2(TCM_SIZE*8/DWIDTH)-1:0]        mem_addr,
  output logic [DWIDTH-1:0]                           mem_wdata,
  input  logic [DWIDTH-1:0]                           mem_rdata
);

  localparam int unsigned NB   = DWIDTH / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned AW   = $clog2(TCM_SIZE * 8 / DWIDTH);
  localparam logic [32:0] TCM_LIM = 33'(TCM_SIZE);

  logic              imem_gnt, dmem_gnt;
  logic              d_misalign, d_err, i_err;
  logic [OFFW-1:0]   d_off, off_q;
  logic [DWIDTH-1:0] d_wdata_rep;
  tcm_owner_e        owner_q;

  scr1_tcm_arb_sel #(
    .ARB_MODE   (ARB_MODE),
    .STARVE_MAX (STARVE_MAX)
  ) u_sel (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .imem_gnt_c (imem_gnt),
    .dmem_gnt_c (dmem_gnt)
  );

  assign imem_req_ack = imem_gnt;
  assign dmem_req_ack = dmem_gnt;
  assign d_off        = dmem_addr[OFFW-1:0];

  // Natural alignment: hword on even bytes, word on 4-byte boundaries
  always_comb begin
    d_misalign = 1'b0;
    case (dmem_width)
      SCR1_MEM_WIDTH_BYTE:  d_misalign = 1'b0;
      SCR1_MEM_WIDTH_HWORD: d_misalign = dmem_addr[0];
      default:              d_misalign = (dmem_addr[1:0] != 2'b00);
    endcase
  end

  assign d_err = ({1'b0, dmem_addr} >= TCM_LIM) || d_misalign;
  assign i_err = ({1'b0, imem_addr} >= TCM_LIM);

  always_comb begin
    d_wdata_rep = '0;
    case (dmem_width)
      SCR1_MEM_WIDTH_BYTE:  d_wdata_rep = {NB{dmem_wdata[7:0]}};
      SCR1_MEM_WIDTH_HWORD: d_wdata_rep = {(NB/2){dmem_wdata[15:0]}};
      default:              d_wdata_rep = {(NB/4){dmem_wdata[31:0]}};
    endcase
  end

  // Memory access issued in the grant cycle; errored requests never touch the array
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dmem_gnt && !d_err) begin
      mem_en    = 1'b1;
      mem_we    = (dmem_cmd == SCR1_MEM_CMD_WR);
      mem_be    = NB'(tcm_lane_mask(dmem_width, 3'(d_off)));
      mem_addr  = dmem_addr[OFFW +: AW];
      mem_wdata = d_wdata_rep;
    end else if (imem_gnt && !i_err) begin
      mem_en    = 1'b1;
      mem_be    = '1;
      mem_addr  = imem_addr[OFFW +: AW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= TCM_OWNER_NONE;
      imem_resp <= SCR1_MEM_RESP_NOTRDY;
      dmem_resp <= SCR1_MEM_RESP_NOTRDY;
      off_q     <= '0;
    end else begin
      owner_q   <= TCM_OWNER_NONE;
      imem_resp <= SCR1_MEM_RESP_NOTRDY;
      dmem_resp <= SCR1_MEM_RESP_NOTRDY;
      if (dmem_gnt) begin
        owner_q   <= TCM_OWNER_DMEM;
        dmem_resp <= d_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        off_q     <= d_off;
      end else if (imem_gnt) begin
        owner_q   <= TCM_OWNER_IMEM;
        imem_resp <= i_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      end
    end
  end

  assign imem_rdata = (owner_q == TCM_OWNER_IMEM) ? mem_rdata : '0;
  assign dmem_rdata = (owner_q == TCM_OWNER_DMEM) ? (mem_rdata >> {off_q, 3'b000}) : '0;

endmodule
